shifter_seq: RTL and testbench

SHIFTER_SEQ -- requirements
Module: shifter_seq

---
 rtl/shifter_seq.sv | 104 ++++++++++
 tb/tb_shifter_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/shifter_seq.sv
// Sequential shifter/rotator: one 1-bit step per clock.
// Multi-bit shifts hold busy until the last step completes.
module shifter_seq #(
  parameter int WIDTH = 16,
  parameter int SH_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       op,
  input  logic [SH_W-1:0]  shamt,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_LSL  = 3'b010;
  localparam logic [2:0] OP_LSR  = 3'b011;
  localparam logic [2:0] OP_ASR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ROR  = 3'b110;

  localparam logic [SH_W-1:0] ONE  = SH_W'(1);
  localparam logic [SH_W-1:0] ZERO = '0;

  logic [0:0]      state;
  logic [2:0]      op_q;
  logic [SH_W-1:0] cnt;

  assign busy      = (state == SHIFT);
  assign cmd_ready = !busy;

  function automatic logic [WIDTH-1:0] step1(
    input logic [2:0]       o,
    input logic [WIDTH-1:0] v
  );
    logic [WIDTH-1:0] r;
    r = v;
    case (o)
      OP_LSL:  r = {v[WIDTH-2:0], 1'b0};
      OP_LSR:  r = {1'b0, v[WIDTH-1:1]};
      OP_ASR:  r = {v[WIDTH-1], v[WIDTH-1:1]};
      OP_ROL:  r = {v[WIDTH-2:0], v[WIDTH-1]};
      OP_ROR:  r = {v[0], v[WIDTH-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op_q  <= OP_NOP;
      cnt   <= ZERO;
      d_out <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state == SHIFT) begin
        d_out <= step1(op_q, d_out);
        cnt   <= cnt - ONE;
        if (cnt == ONE) begin
          done  <= 1'b1;
          state <= IDLE;
        end
      end else if (cmd_valid) begin
        case (op)
          OP_NOP: done <= 1'b1;
          OP_LOAD: begin
            d_out <= d_in;
            done  <= 1'b1;
          end
          OP_LSL, OP_LSR, OP_ASR, OP_ROL, OP_ROR: begin
            if (shamt == ZERO) begin
              done <= 1'b1;
            end else begin
              // first step happens on the accept edge itself
              d_out <= step1(op, d_out);
              op_q  <= op;
              cnt   <= shamt - ONE;
              if (shamt == ONE) done <= 1'b1;
              else state <= SHIFT;
            end
          end
          default: begin
            done <= 1'b1;
            err  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shifter_seq.sv
// Bench for shifter_seq: directed cases plus random commands
// checked against a whole-amount arithmetic reference model.
module tb_shifter_seq;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   op;
  logic [S-1:0] shamt;
  logic [W-1:0] d_in;
  logic [W-1:0] d_out;
  logic         busy;
  logic         done;
  logic         err;

  int ntests = 0;
  int nfail  = 0;
  logic [W-1:0] m;

  shifter_seq #(.WIDTH(W), .SH_W(S)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .op(op), .shamt(shamt), .d_in(d_in),
    .d_out(d_out), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [2:0] o,
                                          input logic [W-1:0] v,
                                          input int k,
                                          input logic [W-1:0] din);
    logic [W-1:0] r;
    case (o)
      3'd1: r = din;
      3'd2: r = v << k;
      3'd3: r = v >> k;
      3'd4: r = $signed(v) >>> k;
      3'd5: r = (k == 0) ? v : ((v << k) | (v >> (W - k)));
      3'd6: r = (k == 0) ? v : ((v >> k) | (v << (W - k)));
      default: r = v;
    endcase
    return r;
  endfunction

  task automatic run_cmd(input string tag, input logic [2:0] o,
                         input int k, input logic [W-1:0] din);
    logic [W-1:0] exp;
    int lat;
    int edges;
    exp = ref_op(o, m, k, din);
    lat = (o >= 3'd2 && o <= 3'd6 && k > 0) ? k : 1;
    cmd_valid = 1'b1;
    op = o;
    shamt = S'(k);
    d_in = din;
    tick();
    cmd_valid = 1'b0;
    d_in = ~din;
    edges = 1;
    if (lat > 1) begin
      check({tag, ".busy"}, {31'd0, busy}, 32'd1);
      check({tag, ".rdy"}, {31'd0, cmd_ready}, 32'd0);
    end
    while (!done && edges < 40) begin
      tick();
      edges++;
    end
    check({tag, ".done"}, {31'd0, done}, 32'd1);
    check({tag, ".lat"}, edges, lat);
    check({tag, ".dout"}, {16'd0, d_out}, {16'd0, exp});
    check({tag, ".err"}, {31'd0, err}, {31'd0, (o == 3'd7)});
    check({tag, ".rdy2"}, {31'd0, cmd_ready}, 32'd1);
    m = exp;
    tick();
    check({tag, ".pulse"}, {30'd0, done, err}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    op = 3'd0;
    shamt = '0;
    d_in = '0;
    m = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst.dout", {16'd0, d_out}, 32'd0);
    check("rst.flags", {29'd0, busy, done, err}, 32'd0);
    check("rst.rdy", {31'd0, cmd_ready}, 32'd1);

    run_cmd("load", 3'd1, 0, 16'h8421);
    run_cmd("asr3", 3'd4, 3, 16'h0000);
    check("asr3.val", {16'd0, d_out}, 32'h0000F084);
    run_cmd("ld2", 3'd1, 0, 16'h8421);
    run_cmd("rol15", 3'd5, 15, 16'h0);
    check("rol15.val", {16'd0, d_out}, 32'h0000C210);
    run_cmd("ld3", 3'd1, 0, 16'h8421);
    run_cmd("lsl4", 3'd2, 4, 16'h0);
    check("lsl4.val", {16'd0, d_out}, 32'h00004210);
    run_cmd("ld4", 3'd1, 0, 16'h8421);
    run_cmd("lsr15", 3'd3, 15, 16'h0);
    check("lsr15.val", {16'd0, d_out}, 32'h00000001);
    run_cmd("lsr0", 3'd3, 0, 16'hFFFF);
    run_cmd("rsv", 3'd7, 5, 16'hFFFF);
    run_cmd("nop", 3'd0, 7, 16'hAAAA);

    // LOAD held on cmd_valid during ROR 8 is ignored until done
    run_cmd("ld5", 3'd1, 0, 16'h8421);
    begin
      int edges;
      logic [W-1:0] exp;
      exp = ref_op(3'd6, m, 8, '0);
      cmd_valid = 1'b1;
      op = 3'd6;
      shamt = S'(8);
      tick();
      op = 3'd1;
      d_in = 16'h1234;
      edges = 1;
      while (!done && edges < 40) begin
        tick();
        edges++;
      end
      check("hold.lat", edges, 8);
      check("hold.dout", {16'd0, d_out}, {16'd0, exp});
      tick();
      cmd_valid = 1'b0;
      check("hold.ld", {16'd0, d_out}, 32'h00001234);
      check("hold.done", {31'd0, done}, 32'd1);
      m = 16'h1234;
      tick();
    end

    // reset aborts LSL 10 mid-way
    cmd_valid = 1'b1;
    op = 3'd2;
    shamt = S'(10);
    tick();
    cmd_valid = 1'b0;
    repeat (4) tick();
    check("abort.busy0", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort.dout", {16'd0, d_out}, 32'd0);
    check("abort.flags", {29'd0, busy, done, err}, 32'd0);
    begin
      int seen;
      seen = 0;
      repeat (12) begin
        tick();
        if (done) seen++;
      end
      check("abort.nodone", seen, 0);
    end
    m = '0;
    run_cmd("ld6", 3'd1, 0, 16'h5A5A);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] o;
      int k;
      logic [W-1:0] din;
      o = 3'($urandom_range(0, 7));
      k = $urandom_range(0, W - 1);
      din = W'($urandom);
      run_cmd("rand", o, k, din);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
